// File: rtl/game_board_ctrl.sv
// ----------------------------------------------------------------------------
// game_board_ctrl
// Game-state engine for a 3x3 tic-tac-toe board. It accepts confirmed cell
// positions through a level request / pulse acknowledge handshake, validates
// and commits each move for the current player, alternates turns and detects
// a win (with the mask of every completed line) or a draw.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset, clears all state
//   new_game    synchronous clear of board and game status (level)
//   move_req    move request, held until move_ack or move_err
//   move_pos    requested cell, row*3+col (0..8 valid)
//   move_ack    one-cycle pulse, move accepted and committed
//   move_err    one-cycle pulse, move rejected
//   board_x     bit i set = cell i holds X
//   board_o     bit i set = cell i holds O
//   turn        player to move (0 = X, 1 = O)
//   move_count  marks placed in the current game (0..9)
//   game_over   high once a win or draw is detected
//   winner      00 none, 01 X, 10 O, 11 draw
//   win_line    OR of the cells of every completed line, 0 if no win
// ----------------------------------------------------------------------------
module game_board_ctrl #(
   parameter logic START_PLAYER = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       new_game,
   input  logic       move_req,
   input  logic [3:0] move_pos,
   output logic       move_ack,
   output logic       move_err,
   output logic [8:0] board_x,
   output logic [8:0] board_o,
   output logic       turn,
   output logic [3:0] move_count,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [8:0] win_line
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t     state_r;
   logic       armed_r;

   logic       consume_s;
   logic       pos_ok_s;
   logic       cell_free_s;
   logic [8:0] pos_mask_s;
   logic [8:0] mover_board_s;
   logic [8:0] lines_s;

   // OR of the masks of every line fully owned by the given board.
   function automatic logic [8:0] completed_lines(input logic [8:0] b);
      logic [8:0] m;
      m = 9'h000;
      if ((b & 9'h007) == 9'h007) m = m | 9'h007;
      if ((b & 9'h038) == 9'h038) m = m | 9'h038;
      if ((b & 9'h1C0) == 9'h1C0) m = m | 9'h1C0;
      if ((b & 9'h049) == 9'h049) m = m | 9'h049;
      if ((b & 9'h092) == 9'h092) m = m | 9'h092;
      if ((b & 9'h124) == 9'h124) m = m | 9'h124;
      if ((b & 9'h111) == 9'h111) m = m | 9'h111;
      if ((b & 9'h054) == 9'h054) m = m | 9'h054;
      return m;
   endfunction

   // Request qualification, cell validity and win evaluation of the mover.
   always_comb begin
      pos_ok_s      = (move_pos <= 4'd8);
      pos_mask_s    = pos_ok_s ? (9'd1 << move_pos) : 9'd0;
      cell_free_s   = (((board_x | board_o) & pos_mask_s) == 9'd0);
      // A request is never consumed in CHECK (it waits) nor under new_game.
      consume_s     = move_req & armed_r & ~new_game & (state_r != CHECK);
      if (turn) begin
         mover_board_s = board_o;
      end else begin
         mover_board_s = board_x;
      end
      lines_s       = completed_lines(mover_board_s);
   end

   // Game FSM with registered board, status and handshake outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         armed_r    <= 1'b0;
         move_ack   <= 1'b0;
         move_err   <= 1'b0;
         board_x    <= 9'd0;
         board_o    <= 9'd0;
         turn       <= START_PLAYER;
         move_count <= 4'd0;
         game_over  <= 1'b0;
         winner     <= 2'b00;
         win_line   <= 9'd0;
      end else begin
         move_ack <= 1'b0;
         move_err <= 1'b0;

         // Re-arm whenever the request is seen low; disarm on consumption.
         if (!move_req) begin
            armed_r <= 1'b1;
         end else if (consume_s) begin
            armed_r <= 1'b0;
         end else begin
            armed_r <= armed_r;
         end

         if (new_game) begin
            state_r    <= IDLE;
            board_x    <= 9'd0;
            board_o    <= 9'd0;
            turn       <= START_PLAYER;
            move_count <= 4'd0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
            win_line   <= 9'd0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (consume_s) begin
                     if (pos_ok_s && cell_free_s) begin
                        if (turn) begin
                           board_o <= board_o | pos_mask_s;
                        end else begin
                           board_x <= board_x | pos_mask_s;
                        end
                        move_count <= move_count + 4'd1;
                        move_ack   <= 1'b1;
                        state_r    <= CHECK;
                     end else begin
                        move_err <= 1'b1;
                     end
                  end
               end
               CHECK: begin
                  // A win takes precedence over the board being full.
                  if (lines_s != 9'd0) begin
                     winner    <= turn ? 2'b10 : 2'b01;
                     win_line  <= lines_s;
                     game_over <= 1'b1;
                     state_r   <= DONE;
                  end else if (move_count == 4'd9) begin
                     winner    <= 2'b11;
                     game_over <= 1'b1;
                     state_r   <= DONE;
                  end else begin
                     turn    <= ~turn;
                     state_r <= IDLE;
                  end
               end
               DONE: begin
                  if (consume_s) begin
                     move_err <= 1'b1;
                  end
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
